// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and pixel types for the sync generator,
// renderer and position-to-cell mapper.
package vga_timing_pkg;

    // 640x480 @ 60 Hz reference timing
    localparam int unsigned DEF_H_ACTIVE  = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_ACTIVE  = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;
    localparam int unsigned DEF_CLK_DIV   = 4;
    localparam int unsigned DEF_COLOR_LAT = 1;

    // Position and colour widths
    localparam int unsigned POS_W   = 10;
    localparam int unsigned CHAN_W  = 4;
    localparam int unsigned COLOR_W = 3 * CHAN_W;

    typedef logic [COLOR_W-1:0] rgb444_t;

    // One stage of the enable/sync delay line; syncs are active-low
    typedef struct packed {
        logic en;
        logic hs_n;
        logic vs_n;
    } sync_stage_t;

    localparam sync_stage_t SYNC_IDLE = '{en: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..TOTAL-1 on inc_en and decodes the
// active region and the active-low sync window from the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned ACTIVE     = 640,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_END   = 751,
    parameter int unsigned W          = POS_W
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         inc_en,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync_n
);

    logic [W-1:0] count_q;

    // Comparisons are done at 32 bits so no narrow overflow can fake a match
    assign wrap   = (32'(count_q) == TOTAL - 1);
    assign active = (32'(count_q) < ACTIVE);
    assign sync_n = !((32'(count_q) >= SYNC_START) && (32'(count_q) <= SYNC_END));
    assign count  = count_q;

    // Position register: advance on inc_en, return to 0 after the terminal count
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
        end else if (inc_en) begin
            if (wrap) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-clock divider, horizontal/vertical position
// counters, sync decode, a latency-matching delay line and the blanked
// RGB output register.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned COLOR_LAT = DEF_COLOR_LAT
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [COLOR_W-1:0] color_in,
    output logic [POS_W-1:0]   current_row,
    output logic [POS_W-1:0]   current_line,
    output logic               enable,
    output logic               pix_tick,
    output logic               frame_start,
    output logic [CHAN_W-1:0]  vga_r,
    output logic [CHAN_W-1:0]  vga_g,
    output logic [CHAN_W-1:0]  vga_b,
    output logic               vga_hs,
    output logic               vga_vs
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned DIV_W   = 4;

    logic [DIV_W-1:0] div_q;
    logic             tick_q;
    logic             run_q;
    logic             h_wrap, h_active, h_sync_n;
    logic             v_wrap, v_active, v_sync_n;
    sync_stage_t      raw_stage;
    sync_stage_t      stage_in [COLOR_LAT+1];
    sync_stage_t      stage_q  [COLOR_LAT+1];
    rgb444_t          rgb_q;

    // Pixel divider; the tick is registered so it stays low through reset
    // even when CLK_DIV is 1, and run_q keeps enable low until the first edge
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (32'(div_q) == CLK_DIV - 1) begin
                div_q  <= '0;
                tick_q <= 1'b1;
            end else begin
                div_q  <= div_q + DIV_W'(1);
                tick_q <= 1'b0;
            end
        end
    end

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC - 1),
        .W          (POS_W)
    ) u_h_counter (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .inc_en   (tick_q),
        .count    (current_row),
        .wrap     (h_wrap),
        .active   (h_active),
        .sync_n   (h_sync_n)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC - 1),
        .W          (POS_W)
    ) u_v_counter (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .inc_en   (tick_q & h_wrap),
        .count    (current_line),
        .wrap     (v_wrap),
        .active   (v_active),
        .sync_n   (v_sync_n)
    );

    assign enable      = run_q & h_active & v_active;
    assign pix_tick    = tick_q;
    assign frame_start = tick_q & h_wrap & v_wrap;
    assign raw_stage   = '{en: enable, hs_n: h_sync_n, vs_n: v_sync_n};

    // Delay-line taps: stage 0 takes the raw decode, each later stage the previous one
    always_comb begin
        stage_in[0] = raw_stage;
        for (int unsigned i = 1; i <= COLOR_LAT; i++) begin
            stage_in[i] = stage_q[i-1];
        end
    end

    // The colour register sits in parallel with the last sync stage, so it is
    // gated by the enable entering that stage: colour and sync leave together
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i <= COLOR_LAT; i++) begin
                stage_q[i] <= SYNC_IDLE;
            end
            rgb_q <= '0;
        end else begin
            for (int unsigned i = 0; i <= COLOR_LAT; i++) begin
                stage_q[i] <= stage_in[i];
            end
            rgb_q <= stage_in[COLOR_LAT].en ? color_in : '0;
        end
    end

    assign vga_hs = stage_q[COLOR_LAT].hs_n;
    assign vga_vs = stage_q[COLOR_LAT].vs_n;
    assign vga_r  = rgb_q[11:8];
    assign vga_g  = rgb_q[7:4];
    assign vga_b  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: three instances (default timing, and a
// reduced timing at two divider/latency settings) share reset and colour.
module tb_vga_sync_gen;

    localparam int NDUT   = 3;
    localparam int HIST_N = 8192;

    localparam int S_HA = 16, S_HFP = 4, S_HSY = 6, S_HBP = 6;
    localparam int S_VA = 12, S_VFP = 2, S_VSY = 3, S_VBP = 3;

    localparam int P_HA  [NDUT] = '{640, S_HA,  S_HA};
    localparam int P_HFP [NDUT] = '{16,  S_HFP, S_HFP};
    localparam int P_HSY [NDUT] = '{96,  S_HSY, S_HSY};
    localparam int P_HBP [NDUT] = '{48,  S_HBP, S_HBP};
    localparam int P_VA  [NDUT] = '{480, S_VA,  S_VA};
    localparam int P_VFP [NDUT] = '{10,  S_VFP, S_VFP};
    localparam int P_VSY [NDUT] = '{2,   S_VSY, S_VSY};
    localparam int P_VBP [NDUT] = '{33,  S_VBP, S_VBP};
    localparam int P_DIV [NDUT] = '{4,   3,     1};
    localparam int P_LAT [NDUT] = '{1,   2,     0};

    typedef struct packed {
        logic [9:0]  row;
        logic [9:0]  line;
        logic        en;
        logic        tick;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } obs_t;
    typedef obs_t [NDUT-1:0] obs_all_t;

    logic                 clk_in = 1'b0;
    logic                 rst_n_in;
    logic [11:0]          color_in;
    logic [NDUT-1:0][9:0] row_o, line_o;
    logic [NDUT-1:0]      en_o, tick_o, fs_o, hs_o, vs_o;
    logic [NDUT-1:0][3:0] r_o, g_o, b_o;

    obs_all_t    sb_q [$];
    logic [11:0] col_hist [0:HIST_N-1];
    int          k;
    int          checks = 0;
    int          errors = 0;
    bit          done   = 1'b0;

    always #5 clk_in = ~clk_in;

    vga_sync_gen u_dut_def (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .color_in(color_in),
        .current_row(row_o[0]), .current_line(line_o[0]), .enable(en_o[0]),
        .pix_tick(tick_o[0]), .frame_start(fs_o[0]),
        .vga_r(r_o[0]), .vga_g(g_o[0]), .vga_b(b_o[0]),
        .vga_hs(hs_o[0]), .vga_vs(vs_o[0])
    );

    vga_sync_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP),
        .CLK_DIV(3), .COLOR_LAT(2)
    ) u_dut_div3 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .color_in(color_in),
        .current_row(row_o[1]), .current_line(line_o[1]), .enable(en_o[1]),
        .pix_tick(tick_o[1]), .frame_start(fs_o[1]),
        .vga_r(r_o[1]), .vga_g(g_o[1]), .vga_b(b_o[1]),
        .vga_hs(hs_o[1]), .vga_vs(vs_o[1])
    );

    vga_sync_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP),
        .CLK_DIV(1), .COLOR_LAT(0)
    ) u_dut_div1 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .color_in(color_in),
        .current_row(row_o[2]), .current_line(line_o[2]), .enable(en_o[2]),
        .pix_tick(tick_o[2]), .frame_start(fs_o[2]),
        .vga_r(r_o[2]), .vga_g(g_o[2]), .vga_b(b_o[2]),
        .vga_hs(hs_o[2]), .vga_vs(vs_o[2])
    );

    // ---- reference model: state after edge kk since reset release ----
    // kk < 0 means "in reset". Pixel index = ticks already consumed, where a
    // tick is present after every edge that is a multiple of CLK_DIV.
    function automatic int h_total(input int d);
        return P_HA[d] + P_HFP[d] + P_HSY[d] + P_HBP[d];
    endfunction

    function automatic int v_total(input int d);
        return P_VA[d] + P_VFP[d] + P_VSY[d] + P_VBP[d];
    endfunction

    function automatic void pos_at(input int d, input int kk, output int row, output int line);
        int p;
        p    = (kk < 1) ? 0 : (kk - 1) / P_DIV[d];
        row  = p % h_total(d);
        line = (p / h_total(d)) % v_total(d);
    endfunction

    function automatic bit en_at(input int d, input int kk);
        int row, line;
        if (kk < 1) return 1'b0;
        pos_at(d, kk, row, line);
        return (row < P_HA[d]) && (line < P_VA[d]);
    endfunction

    function automatic bit hs_at(input int d, input int kk);
        int row, line, s;
        if (kk < 0) return 1'b1;
        pos_at(d, kk, row, line);
        s = P_HA[d] + P_HFP[d];
        return !((row >= s) && (row < s + P_HSY[d]));
    endfunction

    function automatic bit vs_at(input int d, input int kk);
        int row, line, s;
        if (kk < 0) return 1'b1;
        pos_at(d, kk, row, line);
        s = P_VA[d] + P_VFP[d];
        return !((line >= s) && (line < s + P_VSY[d]));
    endfunction

    function automatic obs_t expect_at(input int d, input int kk);
        obs_t e;
        int   row, line, dl;
        pos_at(d, kk, row, line);
        dl     = kk - 1 - P_LAT[d];
        e.row  = 10'(row);
        e.line = 10'(line);
        e.en   = en_at(d, kk);
        e.tick = (kk >= P_DIV[d]) && ((kk % P_DIV[d]) == 0);
        e.fs   = e.tick && (row == h_total(d) - 1) && (line == v_total(d) - 1);
        e.hs   = hs_at(d, dl);
        e.vs   = vs_at(d, dl);
        e.rgb  = (en_at(d, dl) && kk >= 0 && kk < HIST_N) ? col_hist[kk] : 12'h000;
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive the colour for the next edge and queue the expected response
    task automatic drive_and_push(input bit white);
        logic [11:0] c;
        obs_all_t    e;
        c        = white ? 12'hFFF : 12'($urandom);
        color_in = c;
        if (k >= 0 && k < HIST_N) col_hist[k] = c;
        for (int d = 0; d < NDUT; d++) e[d] = expect_at(d, k);
        sb_q.push_back(e);
    endtask

    // Monitor: after every rising edge pop one expectation and compare
    initial begin : monitor
        obs_all_t e, a;
        forever begin
            @(posedge clk_in);
            #1;
            if (done) break;
            for (int d = 0; d < NDUT; d++) begin
                a[d] = {row_o[d], line_o[d], en_o[d], tick_o[d], fs_o[d],
                        hs_o[d], vs_o[d], r_o[d], g_o[d], b_o[d]};
            end
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow at t=%0t", $time);
            end else begin
                e = sb_q.pop_front();
                for (int d = 0; d < NDUT; d++) begin
                    checks++;
                    if (a[d] !== e[d]) begin
                        errors++;
                        $display("FAIL dut%0d t=%0t: got row=%0d line=%0d en=%b tick=%b fs=%b hs=%b vs=%b rgb=%h; expected row=%0d line=%0d en=%b tick=%b fs=%b hs=%b vs=%b rgb=%h",
                                 d, $time, a[d].row, a[d].line, a[d].en, a[d].tick, a[d].fs,
                                 a[d].hs, a[d].vs, a[d].rgb, e[d].row, e[d].line, e[d].en,
                                 e[d].tick, e[d].fs, e[d].hs, e[d].vs, e[d].rgb);
                    end
                end
            end
        end
    end

    // Stimulus: reset, white field then random colour, async reset inside
    // hsync of the default instance (row 700), release and run on
    initial begin : stimulus
        rst_n_in = 1'b0;
        k        = -1;
        drive_and_push(1'b0);
        repeat (4) begin
            @(negedge clk_in);
            drive_and_push(1'b0);
        end

        @(negedge clk_in);
        rst_n_in = 1'b1;
        k        = 1;
        drive_and_push(1'b1);
        repeat (2801) begin
            @(negedge clk_in);
            k++;
            drive_and_push(k < 2600);
        end

        // Default instance is at row 700 here, inside its sync pulse
        @(negedge clk_in);
        chk("hs_low_at_row700", int'(hs_o[0]), 0);
        chk("row700_before_reset", int'(row_o[0]), 700);
        #1;
        rst_n_in = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("async_rst_hs_dut%0d", d), int'(hs_o[d]), 1);
            chk($sformatf("async_rst_row_dut%0d", d), int'(row_o[d]), 0);
            chk($sformatf("async_rst_line_dut%0d", d), int'(line_o[d]), 0);
            chk($sformatf("async_rst_en_dut%0d", d), int'(en_o[d]), 0);
        end
        k = -1;
        drive_and_push(1'b0);
        repeat (4) begin
            @(negedge clk_in);
            drive_and_push(1'b0);
        end

        @(negedge clk_in);
        rst_n_in = 1'b1;
        k        = 1;
        drive_and_push(1'b0);
        repeat (5999) begin
            @(negedge clk_in);
            k++;
            drive_and_push(1'b0);
        end

        @(negedge clk_in);
        done = 1'b1;
        @(posedge clk_in);
        #3;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
